// File: rtl/superga_pkg.sv
// Shared SuperGA pixel-pipeline definitions: coordinate and error widths
// plus the raster FSM state encoding.
package superga_pkg;

   localparam int COORD_W = 8;
   localparam int DELTA_W = 10;
   localparam int ERR_W   = 11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      DRAW  = 2'd2,
      DONE  = 2'd3
   } raster_state_t;

   // Unsigned distance between two coordinates, widened to a signed delta.
   function automatic logic signed [DELTA_W-1:0] abs_diff(
      input logic [COORD_W-1:0] a,
      input logic [COORD_W-1:0] b
   );
      logic signed [DELTA_W-1:0] d;
      if (a > b)
         d = signed'({2'b00, a - b});
      else
         d = signed'({2'b00, b - a});
      return d;
   endfunction

endpackage

// File: rtl/raster_step.sv
// raster_step: one Bresenham step, mapping the current (x, y, err) to the
// next pixel position and error term.
module raster_step
   import superga_pkg::*;
(
   input  logic [COORD_W-1:0]        x,
   input  logic [COORD_W-1:0]        y,
   input  logic signed [ERR_W-1:0]   err,
   input  logic signed [DELTA_W-1:0] dx,
   input  logic signed [DELTA_W-1:0] dy,
   input  logic                      sx_neg,
   input  logic                      sy_neg,
   output logic [COORD_W-1:0]        x_next,
   output logic [COORD_W-1:0]        y_next,
   output logic signed [ERR_W-1:0]   err_next
);

   logic signed [ERR_W:0] e2;
   logic                  step_x;
   logic                  step_y;

   // Both axis moves are decided from the same e2, so a diagonal step
   // accumulates dx and dy into err in one go.
   always_comb begin
      e2       = signed'({err, 1'b0});
      step_x   = (e2 >= (ERR_W + 1)'(dy));
      step_y   = (e2 <= (ERR_W + 1)'(dx));
      err_next = err;
      x_next   = x;
      y_next   = y;
      if (step_x) begin
         err_next = err_next + ERR_W'(dy);
         x_next   = sx_neg ? (x - 1'b1) : (x + 1'b1);
      end
      if (step_y) begin
         err_next = err_next + ERR_W'(dx);
         y_next   = sy_neg ? (y - 1'b1) : (y + 1'b1);
      end
   end

endmodule

// File: rtl/line_raster.sv
// line_raster: Bresenham line rasteriser producing an Xcoord/Ycoord stream.
// Define LINE_RASTER_CLIP_EN to silently step pixels beyond XMAX/YMAX.
module line_raster
   import superga_pkg::*;
#(
   parameter int XMAX = 15,
   parameter int YMAX = 15
) (
   input  logic               ACLK,
   input  logic               ARESET,
   input  logic               CmdValid,
   output logic               CmdReady,
   input  logic [COORD_W-1:0] X0,
   input  logic [COORD_W-1:0] Y0,
   input  logic [COORD_W-1:0] X1,
   input  logic [COORD_W-1:0] Y1,
   output logic [COORD_W-1:0] Xcoord,
   output logic [COORD_W-1:0] Ycoord,
   output logic               PixValid,
   input  logic               PixReady,
   output logic               Busy,
   output logic               Done,
   output logic [1:0]         dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid and ready
   // are both high; a valid source holds its data unchanged until then.

`ifdef LINE_RASTER_CLIP_EN
   localparam bit CLIP_EN = 1'b1;
`else
   localparam bit CLIP_EN = 1'b0;
`endif

   localparam logic [COORD_W-1:0] XLIM = COORD_W'(XMAX);
   localparam logic [COORD_W-1:0] YLIM = COORD_W'(YMAX);

   raster_state_t             state;
   logic [COORD_W-1:0]        x0_r, y0_r, x1_r, y1_r;
   logic [COORD_W-1:0]        x, y;
   logic signed [ERR_W-1:0]   err;
   logic signed [DELTA_W-1:0] dx, dy;
   logic                      sx_neg, sy_neg;

   logic signed [DELTA_W-1:0] dx_calc, dy_calc;
   logic [COORD_W-1:0]        x_next, y_next;
   logic signed [ERR_W-1:0]   err_next;
   logic                      visible, advance, at_end;

   assign dx_calc = abs_diff(x0_r, x1_r);
   assign dy_calc = -abs_diff(y0_r, y1_r);

   // Off-screen pixels advance on their own; visible ones wait for PixReady.
   assign visible = !CLIP_EN || ((x <= XLIM) && (y <= YLIM));
   assign advance = (state == DRAW) && (!visible || PixReady);
   assign at_end  = (x == x1_r) && (y == y1_r);

   raster_step u_step (
      .x        (x),
      .y        (y),
      .err      (err),
      .dx       (dx),
      .dy       (dy),
      .sx_neg   (sx_neg),
      .sy_neg   (sy_neg),
      .x_next   (x_next),
      .y_next   (y_next),
      .err_next (err_next)
   );

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state  <= IDLE;
         x0_r   <= '0;
         y0_r   <= '0;
         x1_r   <= '0;
         y1_r   <= '0;
         x      <= '0;
         y      <= '0;
         err    <= '0;
         dx     <= '0;
         dy     <= '0;
         sx_neg <= 1'b0;
         sy_neg <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (CmdValid) begin
                  x0_r  <= X0;
                  y0_r  <= Y0;
                  x1_r  <= X1;
                  y1_r  <= Y1;
                  state <= SETUP;
               end
            end
            SETUP: begin
               dx     <= dx_calc;
               dy     <= dy_calc;
               sx_neg <= !(x0_r < x1_r);
               sy_neg <= !(y0_r < y1_r);
               err    <= {dx_calc[DELTA_W-1], dx_calc} + {dy_calc[DELTA_W-1], dy_calc};
               x      <= x0_r;
               y      <= y0_r;
               state  <= DRAW;
            end
            DRAW: begin
               if (advance) begin
                  if (at_end) begin
                     state <= DONE;
                  end else begin
                     x   <= x_next;
                     y   <= y_next;
                     err <= err_next;
                  end
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign CmdReady  = (state == IDLE);
   assign Busy      = (state == SETUP) || (state == DRAW);
   assign Done      = (state == DONE);
   assign PixValid  = (state == DRAW) && visible;
   assign Xcoord    = x;
   assign Ycoord    = y;
   assign dbg_state = state;

endmodule
